btb_2way: RTL and testbench
===========================

Name: btb_2way

Overview:
- Clocked, parametrised successor to the combinational BTB: a 2-way set-associative branch target buffer with per-entry 2-bit saturating direction counters.
- Sits beside the IF stage. It gives a same-cycle prediction for the fetch PC (pred_next_pc) and is trained by one registered update per cycle from the EX-stage branch resolution.
- Replaces the old unbounded linear-search table. Lookup is now indexed: bounded depth, tag compare, LRU replacement, flush.

Parameters:
- ADDR_W, 32, PC width.
- IDX_W, 6, set index bits; SETS = 2**IDX_W (64 sets, 128 entries).
- TAG_W, ADDR_W-IDX_W-2, derived; tag = pc[ADDR_W-1:IDX_W+2].
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- if_pc  in  ADDR_W  fetch PC to look up.
- pred_hit  out  1  if_pc matches a valid entry.
- pred_taken  out  1  pred_hit and the matching counter's MSB is 1.
- pred_next_pc  out  ADDR_W  stored target if pred_taken, else if_pc+4.
- upd_valid  in  1  resolved branch/jump this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual target (meaningful when upd_taken=1).
- flush  in  1  invalidate the whole table (fence/context change).

Behaviour:
- Index/tag split: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup is purely combinational from if_pc, with zero latency.
  - Hit = valid & tag match in way0 or way1.
  - Both ways matching cannot occur by construction. If it does, way0 wins.
- Lookup does not modify LRU or counters.
- No write-to-read bypass: a lookup in the same cycle as an update sees pre-edge contents. The update is visible from the next cycle.
- Update, when upd_valid=1 and flush=0, commits on the edge:
  - Hit in way w: counter saturating +1 if taken, -1 if not (00 and 11 saturate). If taken, target is overwritten with upd_target. LRU[idx] is set to point at the other way (w becomes MRU).
  - Miss and taken: choose a victim. The first invalid way is used, way0 preferred; if both are valid, the way named by LRU[idx]. Write valid=1, tag, target=upd_target, ctr=CTR_INIT. The victim becomes MRU.
  - Miss and not taken: no allocation, no state change.
- flush=1: all valid bits and all LRU bits clear on the next edge. flush overrides a simultaneous upd_valid, which is dropped.
- Reset (rst_n=0 at an edge):
  - All valid and LRU bits clear; targets, tags and counters need no reset.
  - While rst_n=0, outputs are forced to pred_hit=0, pred_taken=0, pred_next_pc=if_pc+4.
  - Reset mid-update: the update is dropped.
- Arithmetic: if_pc+4 wraps modulo 2**ADDR_W (0xFFFFFFFC -> 0x00000000). Counters are 2-bit unsigned with saturation, never wrap.
- Storage: use register arrays (combinational read required), not block RAM.

Decomposition:
- Shared package btb_pkg holds:
  - typedef ctr_t (2-bit).
  - Constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Function ctr_next(ctr_t, taken) implementing the saturation.
  - Typedef btb_entry_t {valid, tag, target, ctr}.
- One sub-module is natural: btb_way (one way's tag/target/ctr/valid arrays, combinational read port, single write port), instantiated twice. Top level holds LRU, victim select and output muxing.

Test Plan (IDX_W=6; 0x100, 0x200 and 0x300 all map to idx 0 with tags 1, 2, 3):
1. Reset, then lookup 0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104; lookup 0xFFFFFFFC -> pred_next_pc=0x00000000.
2. Update 0x100 taken, target 0x080 -> same-cycle lookup 0x100 still misses; next cycle hit=1, taken=1, next_pc=0x080.
3. Counter training:
   - Two not-taken updates on 0x100 -> ctr 01 then 00; lookup gives hit=1, taken=0, next_pc=0x104.
   - A third not-taken keeps 00.
   - Three taken updates -> 11; a fourth taken stays 11.
4. Replacement, each step an update taken:
   - 0x100 (way0), 0x200 (way1), then 0x100 again (way0 MRU).
   - Then 0x300 evicts 0x200 -> lookup 0x200 misses; 0x100 and 0x300 hit.
5. Not-taken miss: update 0x400 not taken -> lookup 0x400 still misses, and the entries of idx 0 are unchanged.
6. Flush and reset:
   - With entries present, assert flush together with upd_valid (0x500 taken) -> the next cycle every lookup, including 0x500, misses.
   - Repeat with rst_n=0 for one edge -> same result.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types, counter constants and the saturating counter update used by the
// 2-way branch target buffer.
package btb_pkg;

  localparam int BTB_ADDR_W = 32;
  localparam int BTB_IDX_W  = 6;
  localparam int BTB_TAG_W  = BTB_ADDR_W - BTB_IDX_W - 2;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_ADDR_W-1:0] target;
    ctr_t                  ctr;
  } btb_entry_t;

  // Saturating 2-bit direction counter: never wraps past 00 or 11.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t result;
    result = ctr;
    if (taken) begin
      if (ctr != CTR_ST) result = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: valid/tag/target/counter register arrays with two
// combinational read ports (fetch lookup and update probe) and one write port.
module btb_way
  import btb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [TAG_W-1:0]  a_tag,
  output logic              a_hit,
  output logic [ADDR_W-1:0] a_target,
  output ctr_t              a_ctr,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [TAG_W-1:0]  b_tag,
  output logic              b_hit,
  output logic              b_valid,
  output logic [ADDR_W-1:0] b_target,
  output ctr_t              b_ctr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_target,
  input  ctr_t              wr_ctr
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]   valid_reg;
  logic [TAG_W-1:0]  tag_mem    [SETS];
  logic [ADDR_W-1:0] target_mem [SETS];
  ctr_t              ctr_mem    [SETS];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
      ctr_mem[wr_idx]    <= wr_ctr;
    end
  end

  assign a_hit    = valid_reg[a_idx] && (tag_mem[a_idx] == a_tag);
  assign a_target = target_mem[a_idx];
  assign a_ctr    = ctr_mem[a_idx];

  assign b_valid  = valid_reg[b_idx];
  assign b_hit    = valid_reg[b_idx] && (tag_mem[b_idx] == b_tag);
  assign b_target = target_mem[b_idx];
  assign b_ctr    = ctr_mem[b_idx];

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer: zero-latency fetch prediction,
// one registered training update per cycle, LRU replacement and flush.
module btb_2way
  import btb_pkg::*;
#(
  parameter int   ADDR_W   = 32,
  parameter int   IDX_W    = 6,
  parameter int   TAG_W    = ADDR_W - IDX_W - 2,
  parameter ctr_t CTR_INIT = CTR_WT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush
);

  localparam int SETS = 1 << IDX_W;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             unused_pc_bits;

  assign if_idx         = if_pc[IDX_W+1:2];
  assign if_tag         = if_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx        = upd_pc[IDX_W+1:2];
  assign upd_tag        = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = ^upd_pc[1:0];

  logic [1:0]        a_hit;
  logic [ADDR_W-1:0] a_target [2];
  ctr_t              a_ctr    [2];
  logic [1:0]        b_hit;
  logic [1:0]        b_valid;
  logic [ADDR_W-1:0] b_target [2];
  ctr_t              b_ctr    [2];
  logic [1:0]        way_wr_en;

  logic              do_write;
  logic              wr_way;
  logic [ADDR_W-1:0] wr_target;
  ctr_t              wr_ctr;

  // lru_reg[i] names the way to evict next in set i.
  logic [SETS-1:0]   lru_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign way_wr_en[gi] = do_write && (wr_way == 1'(gi));

      btb_way #(
        .ADDR_W(ADDR_W),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
      ) u_way (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .a_idx    (if_idx),
        .a_tag    (if_tag),
        .a_hit    (a_hit[gi]),
        .a_target (a_target[gi]),
        .a_ctr    (a_ctr[gi]),
        .b_idx    (upd_idx),
        .b_tag    (upd_tag),
        .b_hit    (b_hit[gi]),
        .b_valid  (b_valid[gi]),
        .b_target (b_target[gi]),
        .b_ctr    (b_ctr[gi]),
        .wr_en    (way_wr_en[gi]),
        .wr_idx   (upd_idx),
        .wr_tag   (upd_tag),
        .wr_target(wr_target),
        .wr_ctr   (wr_ctr)
      );
    end
  endgenerate

  // Update path: train the hitting way (way0 wins a double match), otherwise
  // allocate into an invalid way or the LRU victim on a taken miss.
  always_comb begin
    wr_way    = 1'b0;
    wr_target = upd_target;
    wr_ctr    = CTR_INIT;
    if (|b_hit) begin
      wr_way    = b_hit[0] ? 1'b0 : 1'b1;
      wr_ctr    = ctr_next(b_ctr[wr_way], upd_taken);
      wr_target = upd_taken ? upd_target : b_target[wr_way];
    end else if (!b_valid[0]) begin
      wr_way = 1'b0;
    end else if (!b_valid[1]) begin
      wr_way = 1'b1;
    end else begin
      wr_way = lru_reg[upd_idx];
    end
  end

  assign do_write = rst_n && !flush && upd_valid && ((|b_hit) || upd_taken);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      lru_reg <= '0;
    end else if (do_write) begin
      lru_reg[upd_idx] <= ~wr_way;
    end
  end

  logic sel_way;
  assign sel_way      = a_hit[0] ? 1'b0 : 1'b1;
  assign pred_hit     = rst_n && (|a_hit);
  assign pred_taken   = pred_hit && a_ctr[sel_way][1];
  assign pred_next_pc = pred_taken ? a_target[sel_way] : (if_pc + ADDR_W'(4));

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: directed plan with literal expectations,
// then randomized traffic checked every cycle against a behavioural table model.
module tb_btb_2way;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int SETS   = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] if_pc = '0;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [ADDR_W-1:0] upd_target = '0;
  logic              flush = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_2way dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_pc       (if_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_next_pc(pred_next_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush)
  );

  // Behavioural table: per set, two entries plus the way to replace next.
  bit          m_valid  [2][SETS];
  int unsigned m_tag    [2][SETS];
  int unsigned m_target [2][SETS];
  int          m_ctr    [2][SETS];
  int          m_victim [SETS];
  bit          model_ready = 1'b0;

  function automatic int find_way(input int unsigned pc);
    int s;
    int unsigned t;
    s = (pc >> 2) % SETS;
    t = pc >> (IDX_W + 2);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][s] && m_tag[w][s] == t) return w;
    return -1;
  endfunction

  function automatic void predict(input int unsigned pc, output bit hit,
                                  output bit taken, output int unsigned npc);
    int w;
    w     = find_way(pc);
    hit   = rst_n && (w >= 0);
    taken = hit && (m_ctr[w][(pc >> 2) % SETS] >= 2);
    npc   = taken ? m_target[w][(pc >> 2) % SETS] : pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    int s, w, v;
    if (!rst_n || flush) begin
      for (int i = 0; i < SETS; i++) begin
        m_valid[0][i] = 1'b0;
        m_valid[1][i] = 1'b0;
        m_victim[i]   = 0;
      end
      if (!rst_n) model_ready = 1'b1;
    end else if (upd_valid) begin
      s = (upd_pc >> 2) % SETS;
      w = find_way(upd_pc);
      if (w >= 0) begin
        m_ctr[w][s] = upd_taken ? ((m_ctr[w][s] < 3) ? m_ctr[w][s] + 1 : 3)
                                : ((m_ctr[w][s] > 0) ? m_ctr[w][s] - 1 : 0);
        if (upd_taken) m_target[w][s] = upd_target;
        m_victim[s] = 1 - w;
      end else if (upd_taken) begin
        v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : m_victim[s]);
        m_valid[v][s]  = 1'b1;
        m_tag[v][s]    = upd_pc >> (IDX_W + 2);
        m_target[v][s] = upd_target;
        m_ctr[v][s]    = 2;
        m_victim[s]    = 1 - v;
      end
    end
  end

  // Every-cycle comparison against the model (state is pre-edge at negedge).
  always @(negedge clk) begin
    bit e_hit, e_taken;
    int unsigned e_npc;
    if (model_ready) begin
      predict(if_pc, e_hit, e_taken, e_npc);
      checks++;
      if (pred_hit !== e_hit || pred_taken !== e_taken || pred_next_pc !== e_npc) begin
        errors++;
        $display("FAIL model pc=%h got hit=%b taken=%b npc=%h want hit=%b taken=%b npc=%h",
                 if_pc, pred_hit, pred_taken, pred_next_pc, e_hit, e_taken, e_npc);
      end
    end
  end

  task automatic look(input string name, input logic [31:0] pc, input bit e_hit,
                      input bit e_taken, input logic [31:0] e_npc);
    if_pc = pc;
    #1;
    checks++;
    if (pred_hit !== e_hit || pred_taken !== e_taken || pred_next_pc !== e_npc) begin
      errors++;
      $display("FAIL %s pc=%h got hit=%b taken=%b npc=%h want hit=%b taken=%b npc=%h",
               name, pc, pred_hit, pred_taken, pred_next_pc, e_hit, e_taken, e_npc);
    end else begin
      $display("ok %s pc=%h hit=%b taken=%b npc=%h", name, pc, pred_hit, pred_taken, pred_next_pc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // 1. post-reset misses and +4 wrap
    look("rst_miss", 32'h100, 0, 0, 32'h104);
    look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0000_0000);

    // 2. allocation visible only after the edge
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h080;
    look("no_bypass", 32'h100, 0, 0, 32'h104);
    tick();
    look("alloc_hit", 32'h100, 1, 1, 32'h080);

    // 3. counter training and saturation
    upd(32'h100, 0, 32'h0);
    look("ctr_01", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 0, 32'h0);
    look("ctr_00", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 0, 32'h0);
    upd(32'h100, 1, 32'h0C0);
    look("ctr_sat_lo", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 1, 32'h0C0);
    look("ctr_10", 32'h100, 1, 1, 32'h0C0);
    upd(32'h100, 1, 32'h0C0);
    upd(32'h100, 1, 32'h0C0);
    upd(32'h100, 0, 32'h0);
    look("ctr_sat_hi", 32'h100, 1, 1, 32'h0C0);

    // 4. LRU replacement in set 0
    flush = 1'b1;
    tick();
    upd(32'h100, 1, 32'h1A0);
    upd(32'h200, 1, 32'h2A0);
    upd(32'h100, 1, 32'h1A0);
    upd(32'h300, 1, 32'h3A0);
    look("evicted", 32'h200, 0, 0, 32'h204);
    look("mru_kept", 32'h100, 1, 1, 32'h1A0);
    look("new_way", 32'h300, 1, 1, 32'h3A0);

    // 5. not-taken miss allocates nothing
    upd(32'h400, 0, 32'h4A0);
    look("nt_miss", 32'h400, 0, 0, 32'h404);
    look("nt_keep0", 32'h100, 1, 1, 32'h1A0);
    look("nt_keep1", 32'h300, 1, 1, 32'h3A0);

    // 6. flush and reset both drop a concurrent update
    flush = 1'b1;
    upd(32'h500, 1, 32'h5A0);
    look("fl_100", 32'h100, 0, 0, 32'h104);
    look("fl_500", 32'h500, 0, 0, 32'h504);
    upd(32'h100, 1, 32'h1A0);
    rst_n = 1'b0;
    look("rst_force", 32'h100, 0, 0, 32'h104);
    upd(32'h500, 1, 32'h5A0);
    rst_n = 1'b1;
    look("rs_100", 32'h100, 0, 0, 32'h104);
    look("rs_500", 32'h500, 0, 0, 32'h504);

    // Random traffic over a few conflicting sets and tags
    for (int n = 0; n < 3000; n++) begin
      if_pc      = ($urandom_range(0, 4) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      upd_pc     = ($urandom_range(0, 4) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      upd_valid  = ($urandom_range(0, 9) < 7);
      upd_taken  = ($urandom_range(0, 9) < 6);
      upd_target = $urandom;
      flush      = ($urandom_range(0, 99) == 0);
      rst_n      = ($urandom_range(0, 99) != 0);
      if (n % 500 == 499) if_pc = 32'hFFFF_FFFC;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    upd_valid = 1'b0;
    flush = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
